// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit.
// Optional feature macro used elsewhere in this slice: ADDI_OVERFLOW_EN.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [5:0] FN_ADDU   = 6'b100001;
    localparam logic [5:0] FN_SUBU   = 6'b100011;
    localparam logic [5:0] FN_SLT    = 6'b101010;

    localparam logic [1:0] ALU_ADDU  = 2'b00;
    localparam logic [1:0] ALU_SUBU  = 2'b01;
    localparam logic [1:0] ALU_OR    = 2'b10;
    localparam logic [1:0] ALU_LUI   = 2'b11;

    localparam logic [2:0] SRC_ALU    = 3'b000;
    localparam logic [2:0] SRC_MEM    = 3'b001;
    localparam logic [2:0] SRC_CONST0 = 3'b010;
    localparam logic [2:0] SRC_CONST1 = 3'b011;
    localparam logic [2:0] SRC_PC     = 3'b100;

    localparam logic [1:0] DST_RT    = 2'b00;
    localparam logic [1:0] DST_RD    = 2'b01;
    localparam logic [1:0] DST_R30   = 2'b10;
    localparam logic [1:0] DST_R31   = 2'b11;

    typedef enum logic [3:0] {
        I_NOP, I_ADDU, I_SUBU, I_SLT, I_JR, I_ORI, I_BEQ, I_J,
        I_LW, I_SW, I_LUI, I_ADDI, I_ADDIU, I_JAL, I_BLTZAL
    } instr_t;

    typedef struct packed {
        instr_t     instr;
        logic [1:0] alu_ctl;
        logic       alu_src;
        logic       ext_op;
        logic       rtype;
    } decode_t;

    // Instructions that compute in EXEC and commit the ALU result in WB.
    function automatic logic is_alu_op(input instr_t i);
        return i inside {I_ADDU, I_SUBU, I_SLT, I_ORI, I_LUI, I_ADDI, I_ADDIU};
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps opcode/funct to an instruction
// class plus the ALU operand controls that class needs.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output decode_t    dec
);

    always_comb begin
        dec.instr   = I_NOP;
        dec.alu_ctl = ALU_ADDU;
        dec.alu_src = 1'b0;
        dec.ext_op  = 1'b0;
        dec.rtype   = (opcode == OP_RTYPE);
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: dec.instr = I_ADDU;
                    FN_SUBU: begin
                        dec.instr   = I_SUBU;
                        dec.alu_ctl = ALU_SUBU;
                    end
                    // slt is resolved from the sign of rs - rt
                    FN_SLT: begin
                        dec.instr   = I_SLT;
                        dec.alu_ctl = ALU_SUBU;
                    end
                    FN_JR:   dec.instr = I_JR;
                    default: dec.instr = I_NOP;
                endcase
            end
            OP_ORI: begin
                dec.instr   = I_ORI;
                dec.alu_ctl = ALU_OR;
                dec.alu_src = 1'b1;
            end
            OP_LUI: begin
                dec.instr   = I_LUI;
                dec.alu_ctl = ALU_LUI;
                dec.alu_src = 1'b1;
            end
            OP_ADDI: begin
                dec.instr   = I_ADDI;
                dec.alu_src = 1'b1;
                dec.ext_op  = 1'b1;
            end
            OP_ADDIU: begin
                dec.instr   = I_ADDIU;
                dec.alu_src = 1'b1;
                dec.ext_op  = 1'b1;
            end
            OP_LW: begin
                dec.instr   = I_LW;
                dec.alu_src = 1'b1;
                dec.ext_op  = 1'b1;
            end
            OP_SW: begin
                dec.instr   = I_SW;
                dec.alu_src = 1'b1;
                dec.ext_op  = 1'b1;
            end
            OP_BEQ: begin
                dec.instr   = I_BEQ;
                dec.alu_ctl = ALU_SUBU;
            end
            OP_J:      dec.instr = I_J;
            OP_JAL:    dec.instr = I_JAL;
            OP_REGIMM: dec.instr = I_BLTZAL;
            default:   dec.instr = I_NOP;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) for the MIPS subset.
// Define ADDI_OVERFLOW_EN to redirect an overflowing addi to write 1 into $30.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       positive,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] alu_ctl,
    output logic       ext_op,
    output logic [2:0] reg_src,
    output logic       npc_sel,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_src,
    output logic [1:0] reg_dst,
    output logic       j_ctl,
    output logic       jr_ctl,
    output logic [2:0] state
);

    state_t  state_reg;
    state_t  state_next;
    decode_t dec;
    logic    link_take;
    logic    addi_ovf;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .dec    (dec)
    );

    assign link_take = !positive && !zero;
    assign state     = state_reg;

`ifdef ADDI_OVERFLOW_EN
    assign addi_ovf = overflow;
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
    assign addi_ovf        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_next = (dec.instr == I_NOP) ? S_FETCH : S_EXEC;
            S_EXEC: begin
                if (is_alu_op(dec.instr)) begin
                    state_next = S_WB;
                end else if (dec.instr == I_LW || dec.instr == I_SW) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                if (!mem_ready) begin
                    state_next = S_MEM;
                end else begin
                    state_next = (dec.instr == I_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB:     state_next = S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        alu_ctl   = ALU_ADDU;
        ext_op    = 1'b0;
        reg_src   = SRC_ALU;
        npc_sel   = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        alu_src   = 1'b0;
        reg_dst   = DST_RT;
        j_ctl     = 1'b0;
        jr_ctl    = 1'b0;
        if (!reset) begin
            // ALU operand controls stay valid through MEM/WB so the address and
            // overflow flag remain stable while the access or writeback completes.
            if (state_reg inside {S_EXEC, S_MEM, S_WB}) begin
                alu_ctl = dec.alu_ctl;
                alu_src = dec.alu_src;
                ext_op  = dec.ext_op;
            end
            case (state_reg)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_EXEC: begin
                    case (dec.instr)
                        I_BEQ: begin
                            pc_write = zero;
                            npc_sel  = 1'b1;
                        end
                        I_J: begin
                            pc_write = 1'b1;
                            npc_sel  = 1'b1;
                            j_ctl    = 1'b1;
                        end
                        I_JR: begin
                            pc_write = 1'b1;
                            npc_sel  = 1'b1;
                            jr_ctl   = 1'b1;
                        end
                        I_JAL: begin
                            pc_write  = 1'b1;
                            npc_sel   = 1'b1;
                            j_ctl     = 1'b1;
                            reg_write = 1'b1;
                            reg_src   = SRC_PC;
                            reg_dst   = DST_R31;
                        end
                        I_BLTZAL: begin
                            pc_write  = link_take;
                            reg_write = link_take;
                            reg_src   = SRC_PC;
                            reg_dst   = DST_R31;
                            npc_sel   = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    mem_write = (dec.instr == I_SW);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = dec.rtype ? DST_RD : DST_RT;
                    case (dec.instr)
                        I_LW:  reg_src = SRC_MEM;
                        I_SLT: reg_src = positive ? SRC_CONST0 : SRC_CONST1;
                        I_ADDI: begin
                            if (addi_ovf) begin
                                reg_src = SRC_CONST1;
                                reg_dst = DST_R30;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle stimulus and expected outputs
// are queued together, then applied and compared one cycle at a time.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       overflow;
    logic       positive;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] alu_ctl;
    logic       ext_op;
    logic [2:0] reg_src;
    logic       npc_sel;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic       j_ctl;
    logic       jr_ctl;
    logic [2:0] state;

    mc_controller dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .overflow  (overflow),
        .positive  (positive),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .alu_ctl   (alu_ctl),
        .ext_op    (ext_op),
        .reg_src   (reg_src),
        .npc_sel   (npc_sel),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .alu_src   (alu_src),
        .reg_dst   (reg_dst),
        .j_ctl     (j_ctl),
        .jr_ctl    (jr_ctl),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] state;
        logic       mem_req;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] alu_ctl;
        logic       ext_op;
        logic [2:0] reg_src;
        logic       npc_sel;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src;
        logic [1:0] reg_dst;
        logic       j_ctl;
        logic       jr_ctl;
    } outs_t;

    typedef struct packed {
        logic       reset;
        logic [5:0] opcode;
        logic [5:0] funct;
        logic       overflow;
        logic       positive;
        logic       zero;
        logic       mem_ready;
    } stim_t;

    typedef enum {K_NOP, K_ADDU, K_SUBU, K_SLT, K_JR, K_ORI, K_BEQ, K_J,
                  K_LW, K_SW, K_LUI, K_ADDI, K_ADDIU, K_JAL, K_BLTZAL} kind_t;

    stim_t stim_q[$];
    outs_t exp_q[$];
    outs_t mask_q[$];
    string name_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic outs_t observed();
        outs_t o;
        o.state     = state;
        o.mem_req   = mem_req;
        o.ir_write  = ir_write;
        o.pc_write  = pc_write;
        o.alu_ctl   = alu_ctl;
        o.ext_op    = ext_op;
        o.reg_src   = reg_src;
        o.npc_sel   = npc_sel;
        o.mem_write = mem_write;
        o.reg_write = reg_write;
        o.alu_src   = alu_src;
        o.reg_dst   = reg_dst;
        o.j_ctl     = j_ctl;
        o.jr_ctl    = jr_ctl;
        return o;
    endfunction

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        logic [11:0] key;
        key = {op, fn};
        casez (key)
            12'b000000_100001: return K_ADDU;
            12'b000000_100011: return K_SUBU;
            12'b000000_101010: return K_SLT;
            12'b000000_001000: return K_JR;
            12'b001101_??????: return K_ORI;
            12'b000100_??????: return K_BEQ;
            12'b000010_??????: return K_J;
            12'b100011_??????: return K_LW;
            12'b101011_??????: return K_SW;
            12'b001111_??????: return K_LUI;
            12'b001000_??????: return K_ADDI;
            12'b001001_??????: return K_ADDIU;
            12'b000011_??????: return K_JAL;
            12'b000001_??????: return K_BLTZAL;
            default:           return K_NOP;
        endcase
    endfunction

    // ALU controls are only defined in EXEC of instructions that use the ALU;
    // ext_op only matters with an immediate operand; reg_src/reg_dst only with reg_write.
    task automatic push(input string nm, input stim_t s, input outs_t e, input bit care_alu);
        outs_t m;
        m = '1;
        if (!care_alu) begin
            m.alu_ctl = 2'b00;
            m.alu_src = 1'b0;
            m.ext_op  = 1'b0;
        end else if (!e.alu_src) begin
            m.ext_op = 1'b0;
        end
        if (!e.reg_write) begin
            m.reg_src = 3'b000;
            m.reg_dst = 2'b00;
        end
        stim_q.push_back(s);
        exp_q.push_back(e);
        mask_q.push_back(m);
        name_q.push_back(nm);
    endtask

    task automatic push_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                              input logic ov, input logic pos, input logic zr,
                              input int fetch_wait, input int mem_wait);
        stim_t s;
        outs_t e;
        kind_t k;
        bit    care;
        bit    link;
        k = classify(op, fn);
        $display("txn %s op=%b fn=%b ov=%b pos=%b zero=%b fetch_wait=%0d mem_wait=%0d",
                 nm, op, fn, ov, pos, zr, fetch_wait, mem_wait);
        s.reset = 1'b0; s.opcode = op; s.funct = fn;
        s.overflow = ov; s.positive = pos; s.zero = zr; s.mem_ready = 1'b0;
        e = '0; e.state = 3'd0; e.mem_req = 1'b1;
        for (int i = 0; i < fetch_wait; i++) push({nm, ".fetch_wait"}, s, e, 1'b0);
        s.mem_ready = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        push({nm, ".fetch"}, s, e, 1'b0);
        e = '0; e.state = 3'd1;
        push({nm, ".decode"}, s, e, 1'b0);
        if (k == K_NOP) return;

        e = '0; e.state = 3'd2; care = 1'b1;
        case (k)
            K_SUBU, K_SLT: e.alu_ctl = 2'b01;
            K_ORI:   begin e.alu_ctl = 2'b10; e.alu_src = 1'b1; end
            K_LUI:   begin e.alu_ctl = 2'b11; e.alu_src = 1'b1; end
            K_ADDI, K_ADDIU, K_LW, K_SW: begin e.alu_src = 1'b1; e.ext_op = 1'b1; end
            K_BEQ:   begin e.alu_ctl = 2'b01; e.pc_write = zr; e.npc_sel = 1'b1; end
            K_J:     begin care = 1'b0; e.pc_write = 1'b1; e.npc_sel = 1'b1; e.j_ctl = 1'b1; end
            K_JR:    begin care = 1'b0; e.pc_write = 1'b1; e.npc_sel = 1'b1; e.jr_ctl = 1'b1; end
            K_JAL: begin
                care = 1'b0; e.pc_write = 1'b1; e.npc_sel = 1'b1; e.j_ctl = 1'b1;
                e.reg_write = 1'b1; e.reg_src = 3'b100; e.reg_dst = 2'b11;
            end
            K_BLTZAL: begin
                care = 1'b0; link = !pos && !zr;
                e.pc_write = link; e.reg_write = link; e.npc_sel = 1'b1;
                e.reg_src = 3'b100; e.reg_dst = 2'b11;
            end
            default: ;
        endcase
        push({nm, ".exec"}, s, e, care);

        if (k == K_LW || k == K_SW) begin
            e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.mem_write = (k == K_SW);
            s.mem_ready = 1'b0;
            for (int i = 0; i < mem_wait; i++) push({nm, ".mem_wait"}, s, e, 1'b0);
            s.mem_ready = 1'b1;
            push({nm, ".mem"}, s, e, 1'b0);
            if (k == K_SW) return;
        end else if (k inside {K_BEQ, K_J, K_JR, K_JAL, K_BLTZAL}) begin
            return;
        end

        e = '0; e.state = 3'd4; e.reg_write = 1'b1;
        e.reg_dst = (op == 6'b000000) ? 2'b01 : 2'b00;
        if (k == K_LW) e.reg_src = 3'b001;
        else if (k == K_SLT) e.reg_src = pos ? 3'b010 : 3'b011;
`ifdef ADDI_OVERFLOW_EN
        if (k == K_ADDI && ov) begin
            e.reg_src = 3'b011;
            e.reg_dst = 2'b10;
        end
`endif
        push({nm, ".wb"}, s, e, 1'b0);
    endtask

    task automatic test_reset();
        stim_t s;
        outs_t e, m, o;
        string nm;
        s = '0; s.reset = 1'b1; s.mem_ready = 1'b1;
        e = '0;
        push("reset_hold0", s, e, 1'b0);
        push("reset_hold1", s, e, 1'b0);
        push_instr("nop_after_reset", 6'b111111, 6'b000000, 1'b0, 1'b0, 1'b0, 1, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            m = mask_q.pop_front(); nm = name_q.pop_front();
            reset = s.reset; opcode = s.opcode; funct = s.funct; overflow = s.overflow;
            positive = s.positive; zero = s.zero; mem_ready = s.mem_ready;
            @(negedge clk);
            o = observed();
            n_checks++;
            if ((o & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL reset/%s: got %h required %h", nm, o & m, e & m);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_ops();
        stim_t s;
        outs_t e, m, o;
        string nm;
        push_instr("addu",     6'b000000, 6'b100001, 1'b0, 1'b1, 1'b0, 2, 0);
        push_instr("subu",     6'b000000, 6'b100011, 1'b0, 1'b1, 1'b0, 0, 0);
        push_instr("slt_pos",  6'b000000, 6'b101010, 1'b0, 1'b1, 1'b0, 0, 0);
        push_instr("slt_neg",  6'b000000, 6'b101010, 1'b0, 1'b0, 1'b0, 0, 0);
        push_instr("ori",      6'b001101, 6'b010101, 1'b0, 1'b1, 1'b0, 0, 0);
        push_instr("lui",      6'b001111, 6'b000000, 1'b0, 1'b1, 1'b0, 0, 0);
        push_instr("addiu",    6'b001001, 6'b111000, 1'b1, 1'b0, 1'b1, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            m = mask_q.pop_front(); nm = name_q.pop_front();
            reset = s.reset; opcode = s.opcode; funct = s.funct; overflow = s.overflow;
            positive = s.positive; zero = s.zero; mem_ready = s.mem_ready;
            @(negedge clk);
            o = observed();
            n_checks++;
            if ((o & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL alu/%s: got %h required %h", nm, o & m, e & m);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem();
        stim_t s;
        outs_t e, m, o;
        string nm;
        push_instr("lw_wait3", 6'b100011, 6'b000100, 1'b0, 1'b1, 1'b0, 0, 3);
        push_instr("sw",       6'b101011, 6'b000100, 1'b0, 1'b1, 1'b0, 0, 0);
        push_instr("lw",       6'b100011, 6'b001000, 1'b0, 1'b1, 1'b0, 1, 0);
        push_instr("sw_wait2", 6'b101011, 6'b001000, 1'b0, 1'b1, 1'b0, 0, 2);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            m = mask_q.pop_front(); nm = name_q.pop_front();
            reset = s.reset; opcode = s.opcode; funct = s.funct; overflow = s.overflow;
            positive = s.positive; zero = s.zero; mem_ready = s.mem_ready;
            @(negedge clk);
            o = observed();
            n_checks++;
            if ((o & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL mem/%s: got %h required %h", nm, o & m, e & m);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branches();
        stim_t s;
        outs_t e, m, o;
        string nm;
        push_instr("beq_nz",     6'b000100, 6'b000000, 1'b0, 1'b1, 1'b0, 0, 0);
        push_instr("beq_z",      6'b000100, 6'b000000, 1'b0, 1'b1, 1'b1, 0, 0);
        push_instr("j",          6'b000010, 6'b000011, 1'b0, 1'b1, 1'b0, 0, 0);
        push_instr("jr",         6'b000000, 6'b001000, 1'b0, 1'b1, 1'b0, 0, 0);
        push_instr("jal",        6'b000011, 6'b000000, 1'b0, 1'b1, 1'b0, 0, 0);
        push_instr("bltzal_neg", 6'b000001, 6'b000000, 1'b0, 1'b0, 1'b0, 0, 0);
        push_instr("bltzal_pos", 6'b000001, 6'b000000, 1'b0, 1'b1, 1'b0, 0, 0);
        push_instr("bltzal_zer", 6'b000001, 6'b000000, 1'b0, 1'b0, 1'b1, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            m = mask_q.pop_front(); nm = name_q.pop_front();
            reset = s.reset; opcode = s.opcode; funct = s.funct; overflow = s.overflow;
            positive = s.positive; zero = s.zero; mem_ready = s.mem_ready;
            @(negedge clk);
            o = observed();
            n_checks++;
            if ((o & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL branch/%s: got %h required %h", nm, o & m, e & m);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi_overflow();
        stim_t s;
        outs_t e, m, o;
        string nm;
        push_instr("addi_ovf",   6'b001000, 6'b000001, 1'b1, 1'b1, 1'b0, 0, 0);
        push_instr("addi_noovf", 6'b001000, 6'b000001, 1'b0, 1'b1, 1'b0, 0, 0);
        push_instr("addiu_ovf",  6'b001001, 6'b000001, 1'b1, 1'b1, 1'b0, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            m = mask_q.pop_front(); nm = name_q.pop_front();
            reset = s.reset; opcode = s.opcode; funct = s.funct; overflow = s.overflow;
            positive = s.positive; zero = s.zero; mem_ready = s.mem_ready;
            @(negedge clk);
            o = observed();
            n_checks++;
            if ((o & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL addi/%s: got %h required %h", nm, o & m, e & m);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_sw();
        stim_t s;
        outs_t e, m, o;
        string nm;
        $display("txn sw_reset_in_mem op=101011");
        s = '0; s.opcode = 6'b101011; s.positive = 1'b1; s.mem_ready = 1'b1;
        e = '0; e.state = 3'd0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        push("swr.fetch", s, e, 1'b0);
        e = '0; e.state = 3'd1;
        push("swr.decode", s, e, 1'b0);
        e = '0; e.state = 3'd2; e.alu_src = 1'b1; e.ext_op = 1'b1;
        push("swr.exec", s, e, 1'b1);
        s.mem_ready = 1'b0;
        e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.mem_write = 1'b1;
        push("swr.mem_wait", s, e, 1'b0);
        s.reset = 1'b1;
        e = '0; e.state = 3'd3;
        push("swr.reset", s, e, 1'b0);
        push_instr("nop_ff", 6'b111111, 6'b111111, 1'b0, 1'b1, 1'b0, 1, 0);
        push_instr("nop_sll", 6'b000000, 6'b000000, 1'b1, 1'b0, 1'b1, 0, 0);
        push_instr("nop_sb", 6'b101000, 6'b000000, 1'b0, 1'b1, 1'b0, 0, 0);
        push_instr("addu_after", 6'b000000, 6'b100001, 1'b0, 1'b1, 1'b0, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            m = mask_q.pop_front(); nm = name_q.pop_front();
            reset = s.reset; opcode = s.opcode; funct = s.funct; overflow = s.overflow;
            positive = s.positive; zero = s.zero; mem_ready = s.mem_ready;
            @(negedge clk);
            o = observed();
            n_checks++;
            if ((o & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL reset_mid_sw/%s: got %h required %h", nm, o & m, e & m);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; overflow = 1'b0;
        positive = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_alu_ops();
        test_mem();
        test_branches();
        test_addi_overflow();
        test_reset_mid_sw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 opcode  in  6  instruction[31:26] from the instruction register.
REQ-004 funct  in  6  instruction[5:0] from the instruction register.
REQ-005 overflow  in  1  ALU signed overflow.
REQ-006 positive  in  1  ALU result/operand sign-clear flag.
REQ-007 zero  in  1  ALU result zero flag.
REQ-008 mem_ready  in  1  memory access complete this cycle.
REQ-009 mem_req  out  1  memory access request; held until mem_ready.
REQ-010 ir_write  out  1  load instruction register.
REQ-011 pc_write  out  1  update PC from next-PC mux.
REQ-012 alu_ctl  out  2  00 addu, 01 subu, 10 or, 11 lui.
REQ-013 ext_op  out  1  1 = sign-extend immediate, 0 = zero-extend.
REQ-014 reg_src  out  3  000 alu, 001 mem, 010 const 0, 011 const 1, 100 pc.
REQ-015 npc_sel  out  1  1 = branch/jump target, 0 = pc+4.
REQ-016 mem_write  out  1  store strobe.
REQ-017 reg_write  out  1  register-file write strobe.
REQ-018 alu_src  out  1  1 = immediate operand B.
REQ-019 reg_dst  out  2  00 rt, 01 rd, 10 $30, 11 $31.
REQ-020 j_ctl  out  1  jump-target (j/jal) select.
REQ-021 jr_ctl  out  1  register-target (jr) select.
REQ-022 state  out  3  current FSM state, for debug.

Function
REQ-023 Supported: addu, subu, slt, jr, ori, beq, j, lw, sw, lui, addi, addiu, jal, bltzal; any other encoding SHALL execute as a nop (DECODE -> FETCH, no writes).
REQ-024 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH next cycle with all strobes 0.
REQ-025 FETCH: mem_req=1; on mem_ready, ir_write=1, pc_write=1, npc_sel=0 in the same cycle, then -> DECODE; otherwise remain in FETCH.
REQ-026 DECODE: no strobes; -> EXEC.
REQ-027 EXEC, ALU ops (addu/subu/slt/ori/lui/addi/addiu): drive alu_ctl/alu_src/ext_op per instruction; -> WB.
REQ-028 EXEC, beq: alu_ctl=01; pc_write=zero, npc_sel=1; -> FETCH.
REQ-029 EXEC, j: pc_write=1, npc_sel=1, j_ctl=1; -> FETCH. jr: same, but jr_ctl=1, j_ctl=0.
REQ-030 EXEC, jal: reg_write=1, reg_src=100, reg_dst=11, pc_write=1, npc_sel=1, j_ctl=1; -> FETCH.
REQ-031 EXEC, bltzal: pc_write and reg_write (reg_src=100, reg_dst=11) SHALL both equal (!positive && !zero); npc_sel=1; -> FETCH.
REQ-032 EXEC, lw/sw: alu_ctl=00, alu_src=1, ext_op=1; -> MEM.
REQ-033 MEM: mem_req=1, mem_write=1 for sw; hold until mem_ready; on mem_ready sw -> FETCH, lw -> WB.
REQ-034 WB: one-cycle reg_write=1; reg_src 001 for lw; slt: 011 if !positive else 010, reg_dst=01; R-type reg_dst=01; I-type reg_dst=00; -> FETCH.
REQ-035 mem_write and reg_write SHALL never be asserted in the same cycle; every strobe is a single-cycle pulse.
REQ-036 Latency with mem_ready tied 1: ALU ops 4 cycles, lw 5, sw 4, beq/j/jr/jal/bltzal 3.

Reset
REQ-037 While reset=1, all output strobes SHALL be 0 and state SHALL load FETCH on the edge; reset mid-access SHALL abandon the access.
REQ-038 First cycle after reset release: state=0, mem_req=1, all other strobes 0.

Configuration
REQ-039 Macro ADDI_OVERFLOW_EN defined: addi with overflow=1 in WB SHALL write const 1 (reg_src=011) to $30 (reg_dst=10) instead of the result.
REQ-040 Macro undefined: addi SHALL behave exactly as addiu, ignoring overflow.

Structure
REQ-041 Package mc_pkg SHALL hold the state enum, opcode/funct constants and alu_ctl/reg_src/reg_dst encodings.
REQ-042 Combinational instruction decode SHALL be a sub-module, mc_decode; the FSM lives in mc_controller.

Verification
REQ-043 addu (funct 100001), mem_ready=1 -> states 0,1,2,4; WB reg_write=1, reg_dst=01, reg_src=000.
REQ-044 lw, mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_req steady 1, then WB reg_src=001.
REQ-045 beq with zero=0 -> EXEC pc_write=0; with zero=1 -> pc_write=1, npc_sel=1.
REQ-046 addi with overflow=1 -> with ADDI_OVERFLOW_EN reg_dst=10, reg_src=011; without, reg_dst=00, reg_src=000.
REQ-047 reset asserted during MEM of sw -> next cycle state=0, mem_write=0; opcode 111111 -> nop, no writes.
